// File: rtl/gf239_mod_inverse_if.sv
// Operand/result handshake bundle for gf239_mod_inverse.
// Valid/ready rule, both directions: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer keeps valid and
// data stable until that edge. Ready may rise or fall at any time.
interface gf239_mod_inverse_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] din_a;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dout_r;
   logic       dout_err;

   // Operand producer and result consumer (testbench or upstream logic).
   modport master (
      output in_valid, din_a, out_ready,
      input  in_ready, out_valid, dout_r, dout_err
   );

   // The inverter itself.
   modport slave (
      input  in_valid, din_a, out_ready,
      output in_ready, out_valid, dout_r, dout_err
   );
endinterface

// File: rtl/gf239_mod_inverse.sv
// Sequential multiplicative inverse over GF(239) using Fermat's little
// theorem: a^-1 = a^237 mod 239. The exponent is processed MSB first with
// a fixed square-then-multiply schedule, so every exponent bit costs
// exactly two cycles. One Barrett reducer (mu = 274) is shared by both
// steps.
// Optional feature macro: GF239_INV_RANGE_CHECK_EN. When it is defined,
// dout_err flags operands that are 0 or >= 239.
module gf239_mod_inverse (
   input  logic                     clk,
   input  logic                     rst_n,
   gf239_mod_inverse_if.slave       io,
   output logic [1:0]               o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   // The exponent 237 = 8'b1110_1101 is p-2 for p = 239.
   localparam logic [7:0] EXP_E = 8'hED;
   localparam logic [7:0] MOD_P = 8'd239;

   state_t      r_state;
   logic [7:0]  r_base;
   logic [7:0]  r_acc;
   logic [2:0]  r_idx;
   logic        r_in_ready;
   logic        r_out_valid;
   logic [7:0]  r_dout_r;

   logic [7:0]  w_base_in;
   logic [7:0]  w_op_b;
   logic [15:0] w_prod;
   logic [23:0] w_qprod;
   logic [7:0]  w_q;
   logic [15:0] w_rem0;
   logic [15:0] w_rem1;
   logic [15:0] w_rem2;
   logic [7:0]  w_red;

   // Operand capture: din_a is at most 255, so one subtraction suffices.
   always_comb begin
      w_base_in = io.din_a;
      if (io.din_a >= MOD_P)
         w_base_in = io.din_a - MOD_P;
   end

   // Shared multiplier and Barrett reducer. For x < 57121 the quotient
   // estimate (x*274)>>16 undershoots the true quotient by at most 2, so
   // two conditional subtractions always land in 0..238.
   always_comb begin
      w_op_b = 8'd1;
      if (r_state == SQR)
         w_op_b = r_acc;
      else if (EXP_E[r_idx])
         w_op_b = r_base;
      w_prod  = {8'd0, r_acc} * {8'd0, w_op_b};
      w_qprod = {8'd0, w_prod} * 24'd274;
      w_q     = w_qprod[23:16];
      w_rem0  = w_prod - ({8'd0, w_q} * 16'd239);
      w_rem1  = (w_rem0 >= 16'd239) ? (w_rem0 - 16'd239) : w_rem0;
      w_rem2  = (w_rem1 >= 16'd239) ? (w_rem1 - 16'd239) : w_rem1;
      w_red   = w_rem2[7:0];
   end

`ifdef GF239_INV_RANGE_CHECK_EN
   logic r_err_cap;
   logic r_dout_err;

   // Range flag: latched at capture and published together with the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cap  <= 1'b0;
         r_dout_err <= 1'b0;
      end else begin
         if (r_state == IDLE && io.in_valid && r_in_ready)
            r_err_cap <= (io.din_a == 8'd0) || (io.din_a >= MOD_P);
         if (r_state == MUL && r_idx == 3'd0)
            r_dout_err <= r_err_cap;
      end
   end

   assign io.dout_err = r_dout_err;
`else
   assign io.dout_err = 1'b0;
`endif

   // Main controller: capture, 8 x (square, multiply), then hold the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_base      <= 8'd0;
         r_acc       <= 8'd0;
         r_idx       <= 3'd0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_dout_r    <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (io.in_valid && r_in_ready) begin
                  r_base     <= w_base_in;
                  r_acc      <= 8'd1;
                  r_idx      <= 3'd7;
                  r_in_ready <= 1'b0;
                  r_state    <= SQR;
               end
            end
            SQR: begin
               r_acc   <= w_red;
               r_state <= MUL;
            end
            MUL: begin
               r_acc <= w_red;
               if (r_idx == 3'd0) begin
                  r_dout_r    <= w_red;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_idx   <= r_idx - 3'd1;
                  r_state <= SQR;
               end
            end
            DONE: begin
               if (io.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign io.in_ready  = r_in_ready;
   assign io.out_valid = r_out_valid;
   assign io.dout_r    = r_dout_r;
   assign o_dbg_state  = r_state;

endmodule
